// File: rtl/vram_scanner_if.sv
// Scanner-side bus: VRAM read port plus the timed RGB565 video outputs.
`timescale 1ns/1ps
interface vram_scanner_if;
    logic [8:0]  vram_addr;
    logic [3:0]  vram_dout;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [15:0] rgb;
    logic        frame_start;

    modport master (output vram_addr, hsync, vsync, de, rgb, frame_start,
                    input  vram_dout);
    modport slave  (input  vram_addr, hsync, vsync, de, rgb, frame_start,
                    output vram_dout);
endinterface

// File: rtl/vram_scanner.sv
// 640x480@60 raster scanner for the 25x15 tile playfield VRAM, 3-stage pipe to RGB565.
// Optional grid overlay: define VRAM_SCAN_GRID_EN.
`timescale 1ns/1ps
module vram_scanner #(
    parameter int          TILE_PX    = 24,
    parameter int          X_OFF      = 20,
    parameter int          Y_OFF      = 60,
    parameter logic [15:0] BORDER_RGB = 16'h001F
) (
    input logic            clk,
    input logic            rst_n,
    vram_scanner_if.master bus
);
    localparam int COLS = 25;
    localparam int ROWS = 15;
    localparam int SPW  = $clog2(TILE_PX);

    localparam logic [9:0] H_LAST  = 10'd799;
    localparam logic [9:0] V_LAST  = 10'd524;
    localparam logic [9:0] H_VIS   = 10'd640;
    localparam logic [9:0] V_VIS   = 10'd480;
    localparam logic [9:0] HS_BEG  = 10'd656;
    localparam logic [9:0] HS_END  = 10'd752;
    localparam logic [9:0] VS_BEG  = 10'd490;
    localparam logic [9:0] VS_END  = 10'd492;
    localparam logic [9:0] XB      = 10'(X_OFF);
    localparam logic [9:0] XE      = 10'(X_OFF + COLS * TILE_PX);
    localparam logic [9:0] YB      = 10'(Y_OFF);
    localparam logic [9:0] YE      = 10'(Y_OFF + ROWS * TILE_PX);
    localparam logic [SPW-1:0] SP_LAST = SPW'(TILE_PX - 1);
    localparam logic [8:0] RB_LAST = 9'((ROWS - 1) * COLS);

    typedef struct packed {
        logic vis;
        logic hs;
        logic vs;
        logic inf;
        logic fs;
    } ctl_t;

    localparam ctl_t CTL_RST = '{vis: 1'b0, hs: 1'b1, vs: 1'b1, inf: 1'b0, fs: 1'b0};

    logic [9:0]     hcnt, vcnt, hnxt, vnxt;
    logic [SPW-1:0] sx, sy;
    logic [4:0]     col;
    logic [8:0]     row_base;
    ctl_t           ctl0, ctl1, ctl2;
    logic [15:0]    pix;

    function automatic logic [15:0] palette(input logic [3:0] code);
        case (code)
            4'd0:    palette = 16'h0000;
            4'd1:    palette = 16'h07E0;
            4'd2:    palette = 16'hFFE0;
            4'd3:    palette = 16'hF800;
            4'd4:    palette = 16'h8410;
            default: palette = 16'hFFFF;
        endcase
    endfunction

    always_comb begin
        hnxt = (hcnt == H_LAST) ? 10'd0 : hcnt + 10'd1;
        vnxt = vcnt;
        if (hcnt == H_LAST)
            vnxt = (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
        ctl0.vis = (hcnt < H_VIS) && (vcnt < V_VIS);
        ctl0.hs  = !((hcnt >= HS_BEG) && (hcnt < HS_END));
        ctl0.vs  = !((vcnt >= VS_BEG) && (vcnt < VS_END));
        ctl0.inf = (hcnt >= XB) && (hcnt < XE) && (vcnt >= YB) && (vcnt < YE);
        ctl0.fs  = (hcnt == 10'd0) && (vcnt == V_VIS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            hcnt <= hnxt;
            vcnt <= vnxt;
        end
    end

    // Tile position tracks the stage-0 pixel; updated from the *next* counter
    // value so it is already correct on the first in-field pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sx       <= '0;
            col      <= '0;
            sy       <= '0;
            row_base <= '0;
        end else begin
            if (hnxt == XB) begin
                sx  <= '0;
                col <= '0;
            end else if ((hnxt > XB) && (hnxt < XE)) begin
                if (sx == SP_LAST) begin
                    sx  <= '0;
                    col <= col + 5'd1;
                end else begin
                    sx <= sx + 1'b1;
                end
            end
            if (hcnt == H_LAST) begin
                if (vnxt == YB) begin
                    sy       <= '0;
                    row_base <= '0;
                end else if ((vnxt > YB) && (vnxt < YE)) begin
                    if (sy == SP_LAST) begin
                        sy       <= '0;
                        row_base <= (row_base == RB_LAST) ? 9'd0 : row_base + 9'd25;
                    end else begin
                        sy <= sy + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.vram_addr <= '0;
            ctl1          <= CTL_RST;
            ctl2          <= CTL_RST;
        end else begin
            if (ctl0.inf)
                bus.vram_addr <= row_base + 9'(col);
            ctl1 <= ctl0;
            ctl2 <= ctl1;
        end
    end

`ifdef VRAM_SCAN_GRID_EN
    logic grid1, grid2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grid1 <= 1'b0;
            grid2 <= 1'b0;
        end else begin
            grid1 <= (sx == '0) || (sy == '0);
            grid2 <= grid1;
        end
    end

    always_comb begin
        pix = palette(bus.vram_dout);
        if (grid2)
            pix = 16'h2104;
    end
`else
    always_comb begin
        pix = palette(bus.vram_dout);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.hsync       <= 1'b1;
            bus.vsync       <= 1'b1;
            bus.de          <= 1'b0;
            bus.rgb         <= '0;
            bus.frame_start <= 1'b0;
        end else begin
            bus.hsync       <= ctl2.hs;
            bus.vsync       <= ctl2.vs;
            bus.de          <= ctl2.vis;
            bus.frame_start <= ctl2.fs;
            bus.rgb         <= !ctl2.vis ? 16'h0000 : (ctl2.inf ? pix : BORDER_RGB);
        end
    end
endmodule

// File: tb/tb_vram_scanner.sv
// Bench for vram_scanner: randomized VRAM contents checked against a pixel-level raster model.
`timescale 1ns/1ps
module tb_vram_scanner;
    localparam int          TILE_PX    = 24;
    localparam int          X_OFF      = 20;
    localparam int          Y_OFF      = 60;
    localparam logic [15:0] BORDER_RGB = 16'h001F;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] mem [0:511];
    int checks = 0;
    int failures = 0;
    int ncyc = 0;

    vram_scanner_if bus();

    vram_scanner #(.TILE_PX(TILE_PX), .X_OFF(X_OFF), .Y_OFF(Y_OFF), .BORDER_RGB(BORDER_RGB))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #20 clk = ~clk;

    always @(posedge clk) bus.vram_dout <= mem[bus.vram_addr];

    function automatic logic [15:0] pal(input logic [3:0] c);
        case (c)
            4'd0:    return 16'h0000;
            4'd1:    return 16'h07E0;
            4'd2:    return 16'hFFE0;
            4'd3:    return 16'hF800;
            4'd4:    return 16'h8410;
            default: return 16'hFFFF;
        endcase
    endfunction

    function automatic bit in_field(input int h, input int v);
        return h >= X_OFF && h < X_OFF + 25 * TILE_PX && v >= Y_OFF && v < Y_OFF + 15 * TILE_PX;
    endfunction

    function automatic int fld_addr(input int h, input int v);
        return ((v - Y_OFF) / TILE_PX) * 25 + (h - X_OFF) / TILE_PX;
    endfunction

    // Expected {hsync, vsync, de, frame_start, rgb} for raster pixel index p.
    function automatic logic [19:0] model(input int p);
        int h, v;
        logic hs, vs, de, fs;
        logic [15:0] rgb;
        h   = p % 800;
        v   = (p / 800) % 525;
        hs  = !(h >= 656 && h < 752);
        vs  = !(v >= 490 && v < 492);
        de  = h < 640 && v < 480;
        fs  = h == 0 && v == 480;
        rgb = 16'h0000;
        if (de) begin
            if (in_field(h, v)) begin
                rgb = pal(mem[fld_addr(h, v)]);
`ifdef VRAM_SCAN_GRID_EN
                if ((h - X_OFF) % TILE_PX == 0 || (v - Y_OFF) % TILE_PX == 0)
                    rgb = 16'h2104;
`endif
            end else begin
                rgb = BORDER_RGB;
            end
        end
        return {hs, vs, de, fs, rgb};
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 512; i++) mem[i] = 4'($urandom);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.vram_addr !== 9'd0) begin failures++; $display("FAIL reset_vram_addr got=%0d want=0", bus.vram_addr); end
        checks++; if (bus.hsync !== 1'b1) begin failures++; $display("FAIL reset_hsync got=%b want=1", bus.hsync); end
        checks++; if (bus.vsync !== 1'b1) begin failures++; $display("FAIL reset_vsync got=%b want=1", bus.vsync); end
        checks++; if (bus.de !== 1'b0) begin failures++; $display("FAIL reset_de got=%b want=0", bus.de); end
        checks++; if (bus.rgb !== 16'h0) begin failures++; $display("FAIL reset_rgb got=%h want=0000", bus.rgb); end
        checks++; if (bus.frame_start !== 1'b0) begin failures++; $display("FAIL reset_frame_start got=%b want=0", bus.frame_start); end
        rst_n = 1'b1;
        ncyc = 0;
        for (int i = 1; i <= 2; i++) begin
            @(posedge clk); ncyc++; @(negedge clk);
            checks++; if (bus.de !== 1'b0) begin failures++; $display("FAIL release_de clk=%0d got=%b want=0", i, bus.de); end
            checks++; if (bus.hsync !== 1'b1) begin failures++; $display("FAIL release_hsync clk=%0d got=%b want=1", i, bus.hsync); end
        end
    endtask

    task automatic test_raster();
        int bad = 0, hs_low = 0, de_hi = 0, fh = 0;
        logic [19:0] act, exp, fa = '0, fe = '0;
        while (ncyc - 3 < 86 * 800 - 1) begin
            int p, h, v, q;
            @(posedge clk); ncyc++; @(negedge clk);
            p = ncyc - 3; h = p % 800; v = p / 800;
            exp = model(p);
            act = {bus.hsync, bus.vsync, bus.de, bus.frame_start, bus.rgb};
            if (act !== exp) begin
                if (bad == 0) begin fa = act; fe = exp; fh = h; end
                bad++;
            end
            q = ncyc - 1;
            if (in_field(q % 800, q / 800) && bus.vram_addr !== 9'(fld_addr(q % 800, q / 800))) begin
                if (bad == 0) begin fa = 20'(bus.vram_addr); fe = 20'(fld_addr(q % 800, q / 800)); fh = q % 800; end
                bad++;
            end
            if (!bus.hsync) hs_low++;
            if (bus.de) de_hi++;
            if (p == 0) begin
                checks++; if (bus.de !== 1'b1) begin failures++; $display("FAIL first_pixel_de got=%b want=1", bus.de); end
            end
            if (h == 10 && v == 10) begin
                checks++; if (bus.rgb !== BORDER_RGB) begin failures++; $display("FAIL border_10_10 got=%h want=%h", bus.rgb, BORDER_RGB); end
            end
            if (h == 700 && v == 10) begin
                checks++; if ({bus.de, bus.rgb} !== 17'h0) begin failures++; $display("FAIL blank_700_10 got de=%b rgb=%h want de=0 rgb=0000", bus.de, bus.rgb); end
            end
            if (h == 799) begin
                checks++; if (bad !== 0) begin failures++; $display("FAIL raster_line%0d bad=%0d first h=%0d got=%h want=%h", v, bad, fh, fa, fe); end
                checks++; if (hs_low !== 96) begin failures++; $display("FAIL hsync_width line%0d got=%0d want=96", v, hs_low); end
                checks++; if (de_hi !== (v < 480 ? 640 : 0)) begin failures++; $display("FAIL de_count line%0d got=%0d want=640", v, de_hi); end
                bad = 0; hs_low = 0; de_hi = 0;
            end
        end
    endtask

    task automatic test_all_food();
        int bad = 0, nf = 0, fh = 0;
        logic [16:0] fa = '0, fe = '0;
        // Output pixel is in the right blank: no in-field read is in flight.
        for (int i = 0; i < 512; i++) mem[i] = 4'd3;
        while (ncyc - 3 < 90 * 800 - 1) begin
            int p, h, v;
            logic [16:0] exp;
            @(posedge clk); ncyc++; @(negedge clk);
            p = ncyc - 3; h = p % 800; v = p / 800;
            exp = {1'b0, 16'h0};
            if (h < 640) exp = {1'b1, in_field(h, v) ? 16'hF800 : BORDER_RGB};
            if (in_field(h, v) && ((h - X_OFF) % TILE_PX == 0 || (v - Y_OFF) % TILE_PX == 0)) exp = {1'b1, bus.rgb};
            else if (in_field(h, v)) nf++;
            if ({bus.de, bus.rgb} !== exp) begin
                if (bad == 0) begin fa = {bus.de, bus.rgb}; fe = exp; fh = h; end
                bad++;
            end
            if (h == 799) begin
                checks++; if (bad !== 0) begin failures++; $display("FAIL food_line%0d bad=%0d first h=%0d got=%h want=%h", v, bad, fh, fa, fe); end
                checks++; if (nf !== 600 - 25) begin failures++; $display("FAIL food_count line%0d got=%0d want=575", v, nf); end
                bad = 0; nf = 0;
            end
        end
    endtask

    task automatic test_reset_mid();
        int k = 0, n = 0;
        while (ncyc - 3 < 90 * 800 + 300) begin
            @(posedge clk); ncyc++; @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.vram_addr !== 9'd0) begin failures++; $display("FAIL mid_vram_addr got=%0d want=0", bus.vram_addr); end
        checks++; if (bus.hsync !== 1'b1) begin failures++; $display("FAIL mid_hsync got=%b want=1", bus.hsync); end
        checks++; if (bus.vsync !== 1'b1) begin failures++; $display("FAIL mid_vsync got=%b want=1", bus.vsync); end
        checks++; if (bus.de !== 1'b0) begin failures++; $display("FAIL mid_de got=%b want=0", bus.de); end
        checks++; if (bus.rgb !== 16'h0) begin failures++; $display("FAIL mid_rgb got=%h want=0000", bus.rgb); end
        checks++; if (bus.frame_start !== 1'b0) begin failures++; $display("FAIL mid_frame_start got=%b want=0", bus.frame_start); end
        repeat (5) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        while (k < 20 && bus.de !== 1'b1) begin
            @(posedge clk); k++; @(negedge clk);
        end
        checks++; if (k !== 3) begin failures++; $display("FAIL mid_de_rise got=%0d want=3", k); end
        checks++; if (bus.rgb !== BORDER_RGB) begin failures++; $display("FAIL mid_first_rgb got=%h want=%h", bus.rgb, BORDER_RGB); end
        while (n < 1000 && bus.de === 1'b1) begin
            @(posedge clk); n++; @(negedge clk);
        end
        checks++; if (n !== 640) begin failures++; $display("FAIL mid_de_run got=%0d want=640", n); end
        n = 0;
        while (n < 1000 && bus.hsync === 1'b1) begin
            @(posedge clk); n++; @(negedge clk);
        end
        checks++; if (n !== 16) begin failures++; $display("FAIL mid_hsync_front got=%0d want=16", n); end
    endtask

    initial begin
        test_reset();
        test_raster();
        test_all_food();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #10_000_000;
        $display("FAIL timeout sim_time=%0t limit=10ms", $time);
        $fatal(1, "timeout");
    end
endmodule
